dda_step_ctrl: RTL and testbench

Sequencer for the 6-bit DDA integrator loop (adder plus output/feedback register).
- Accepts a job of increment value plus step count.
- Clears the accumulator register, then enables it for exactly N update cycles.
- Counts carry-out (overflow) pulses during the run and signals completion with a one-cycle done strobe.
- Sits between the job source and the DDA datapath; the datapath's register sits behind this block's clear/enable.

---
 rtl/dda_step_ctrl.sv | 146 ++++++++++++++
 tb/tb_dda_step_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dda_step_ctrl.sv
// dda_step_ctrl: sequencer for the DDA integrator loop.
// Accepts a job (increment, step count), clears the datapath accumulator,
// enables it for N update cycles, counts carry-out pulses, strobes done.
// Optional build macro DDA_CONT_EN adds i_cont for back-to-back periods
// without clearing the accumulator.
module dda_step_ctrl #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_inc,
    input  logic [CNT_W-1:0] i_nsteps,
    input  logic             i_hold,
    input  logic             i_abort,
`ifdef DDA_CONT_EN
    input  logic             i_cont,
`endif
    input  logic             i_ovf,
    output logic [WIDTH-1:0] o_inc,
    output logic             o_clr,
    output logic             o_en,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_step_cnt,
    output logic [CNT_W-1:0] o_pulse_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] nsteps_q, nsteps_d;
    logic [WIDTH-1:0] inc_d;
    logic             clr_d, en_d, busy_d, done_d;
    logic [CNT_W-1:0] step_d, pulse_d;
    logic [CNT_W-1:0] step_inc;

    assign step_inc = o_step_cnt + CNT_W'(1);

    // Next state and next registered outputs; counters track every load
    // actually issued to the datapath (any cycle with o_en high).
    always_comb begin
        state_d  = state_q;
        nsteps_d = nsteps_q;
        inc_d    = o_inc;
        clr_d    = 1'b0;
        en_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        step_d   = o_step_cnt;
        pulse_d  = o_pulse_cnt;

        if (o_en) begin
            step_d = step_inc;
            if (i_ovf) begin
                pulse_d = o_pulse_cnt + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    inc_d    = i_inc;
                    nsteps_d = i_nsteps;
                    step_d   = '0;
                    pulse_d  = '0;
                    if (i_nsteps == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                        clr_d   = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    en_d    = !i_hold;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (o_en && (step_inc == nsteps_q)) begin
`ifdef DDA_CONT_EN
                    if (i_cont) begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        done_d  = 1'b1;
                        en_d    = !i_hold;
                        step_d  = '0;
                        pulse_d = '0;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    busy_d = 1'b1;
                    en_d   = !i_hold;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            nsteps_q    <= '0;
            o_inc       <= '0;
            o_clr       <= 1'b0;
            o_en        <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_step_cnt  <= '0;
            o_pulse_cnt <= '0;
        end else begin
            state_q     <= state_d;
            nsteps_q    <= nsteps_d;
            o_inc       <= inc_d;
            o_clr       <= clr_d;
            o_en        <= en_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_step_cnt  <= step_d;
            o_pulse_cnt <= pulse_d;
        end
    end

endmodule

// File: tb/tb_dda_step_ctrl.sv
// Bench for dda_step_ctrl: job-level reference model, DDA datapath model,
// per-cycle output comparison, and directed scenarios with literal results.
module tb_dda_step_ctrl;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic [WIDTH-1:0] i_inc = '0;
    logic [CNT_W-1:0] i_nsteps = '0;
    logic             i_hold = 1'b0;
    logic             i_abort = 1'b0;
    logic             i_ovf;
    logic [WIDTH-1:0] o_inc;
    logic             o_clr, o_en, o_busy, o_done;
    logic [CNT_W-1:0] o_step_cnt, o_pulse_cnt;

    always #5 clk = ~clk;

    dda_step_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_inc      (i_inc),
        .i_nsteps   (i_nsteps),
        .i_hold     (i_hold),
        .i_abort    (i_abort),
`ifdef DDA_CONT_EN
        .i_cont     (1'b0),
`endif
        .i_ovf      (i_ovf),
        .o_inc      (o_inc),
        .o_clr      (o_clr),
        .o_en       (o_en),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_step_cnt (o_step_cnt),
        .o_pulse_cnt(o_pulse_cnt)
    );

    // Datapath: accumulator register behind clr/en, carry fed back as i_ovf.
    logic [WIDTH-1:0] dp_acc;
    logic [WIDTH:0]   dp_sum;
    assign dp_sum = {1'b0, dp_acc} + {1'b0, o_inc};
    assign i_ovf  = dp_sum[WIDTH];
    always @(posedge clk) begin
        if (!i_rst_n)   dp_acc <= '0;
        else if (o_clr) dp_acc <= '0;
        else if (o_en)  dp_acc <= dp_sum[WIDTH-1:0];
    end

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: job phase (0 idle, 1 clear, 2 run, 3 done), steps done
    // vs. steps requested, and its own accumulator to derive the carry count.
    int m_mode = 0, m_steps = 0, m_pulses = 0, m_acc = 0, m_inc = 0, m_n = 0;
    bit m_en = 0, m_clr = 0, m_done = 0;

    always @(posedge clk) begin : model
        int md, st, pu, ac, inc, n, s;
        bit en, clr, dn;
        md = m_mode; st = m_steps; pu = m_pulses; ac = m_acc; inc = m_inc; n = m_n;
        en = 0; clr = 0; dn = 0;
        if (!i_rst_n) begin
            md = 0; st = 0; pu = 0; ac = 0; inc = 0; n = 0;
        end else begin
            if (m_en) begin
                s  = ac + inc;
                st = st + 1;
                if (s >= 64) pu = pu + 1;
                ac = s % 64;
            end
            if (m_clr) ac = 0;
            case (md)
                0: if (i_start) begin
                    inc = int'(i_inc); n = int'(i_nsteps); st = 0; pu = 0;
                    if (n == 0) begin md = 3; dn = 1; end
                    else begin md = 1; clr = 1; end
                end
                1: if (i_abort) md = 0;
                   else begin md = 2; en = !i_hold; end
                2: if (i_abort) md = 0;
                   else if (st == n) begin md = 3; dn = 1; end
                   else en = !i_hold;
                default: md = 0;
            endcase
        end
        m_mode <= md; m_steps <= st; m_pulses <= pu; m_acc <= ac;
        m_inc <= inc; m_n <= n; m_en <= en; m_clr <= clr; m_done <= dn;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("o_inc", int'(o_inc), m_inc);
            check("o_clr", int'(o_clr), int'(m_clr));
            check("o_en", int'(o_en), int'(m_en));
            check("o_busy", int'(o_busy), int'(m_mode == 1 || m_mode == 2));
            check("o_done", int'(o_done), int'(m_done));
            check("o_step_cnt", int'(o_step_cnt), m_steps);
            check("o_pulse_cnt", int'(o_pulse_cnt), m_pulses);
        end
    end

    // Job event monitor for the directed scenarios.
    int t0 = 0, clr_rel = -1, done_rel = -1, mon_en = 0, mon_clr = 0, mon_done = 0;
    always @(negedge clk) begin
        if (o_clr) begin
            mon_clr <= mon_clr + 1;
            if (clr_rel < 0) clr_rel <= cyc - t0;
        end
        if (o_en) mon_en <= mon_en + 1;
        if (o_done) begin
            mon_done <= mon_done + 1;
            if (done_rel < 0) done_rel <= cyc - t0;
        end
    end

    task automatic start_job(input int inc, input int n);
        @(posedge clk); #2;
        i_start = 1'b1; i_inc = WIDTH'(inc); i_nsteps = CNT_W'(n);
        t0 = cyc; clr_rel = -1; done_rel = -1; mon_en = 0; mon_clr = 0; mon_done = 0;
        @(posedge clk); #2;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk); #1;
            if (mon_done > 0) seen = 1;
        end
        check({name, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic wait_en(input string name, input int k);
        bit seen;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk); #1;
            if (mon_en >= k) seen = 1;
        end
        check({name, "_en_reached"}, int'(seen), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 i_rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk); #1;
        check("reset_busy", int'(o_busy), 0);
        check("reset_step", int'(o_step_cnt), 0);
        check("reset_inc", int'(o_inc), 0);

        // Basic job: 16 x 8 wraps the 6-bit accumulator twice.
        start_job(16, 8);
        wait_done("basic");
        check("basic_clr_rel", clr_rel, 1);
        check("basic_done_rel", done_rel, 10);
        check("basic_en_cycles", mon_en, 8);
        check("basic_steps", int'(o_step_cnt), 8);
        check("basic_pulses", int'(o_pulse_cnt), 2);
        check("basic_acc", int'(dp_acc), 0);

        // Max increment, 64 steps, with an ignored start mid-run.
        start_job(63, 64);
        repeat (10) @(posedge clk);
        #2 i_start = 1'b1; i_inc = 6'd1; i_nsteps = 8'd3;
        @(posedge clk); #2 i_start = 1'b0;
        wait_done("max");
        check("max_done_rel", done_rel, 66);
        check("max_steps", int'(o_step_cnt), 64);
        check("max_pulses", int'(o_pulse_cnt), 63);
        check("max_inc_kept", int'(o_inc), 63);

        // Hold for three cycles during RUN.
        start_job(16, 8);
        wait_en("hold", 2);
        i_hold = 1'b1;
        repeat (3) @(posedge clk);
        #2 i_hold = 1'b0;
        wait_done("hold");
        check("hold_done_rel", done_rel, 13);
        check("hold_en_cycles", mon_en, 8);
        check("hold_pulses", int'(o_pulse_cnt), 2);

        // Zero-step job.
        start_job(5, 0);
        wait_done("zero");
        check("zero_done_rel", done_rel, 1);
        check("zero_clr", mon_clr, 0);
        check("zero_en", mon_en, 0);
        check("zero_steps", int'(o_step_cnt), 0);

        // Abort during the fifth enabled step.
        start_job(16, 8);
        wait_en("abort", 5);
        i_abort = 1'b1;
        @(posedge clk); #2 i_abort = 1'b0;
        @(negedge clk); #1;
        check("abort_busy", int'(o_busy), 0);
        check("abort_en", int'(o_en), 0);
        check("abort_steps", int'(o_step_cnt), 5);
        check("abort_pulses", int'(o_pulse_cnt), 1);
        repeat (5) @(negedge clk);
        #1 check("abort_no_done", mon_done, 0);

        // Reset in the middle of RUN.
        start_job(16, 8);
        wait_en("rst", 3);
        i_rst_n = 1'b0; i_start = 1'b1;
        @(posedge clk); #2 i_rst_n = 1'b1; i_start = 1'b0;
        @(negedge clk); #1;
        check("rst_busy", int'(o_busy), 0);
        check("rst_en", int'(o_en), 0);
        check("rst_steps", int'(o_step_cnt), 0);
        check("rst_inc", int'(o_inc), 0);
        repeat (5) @(negedge clk);
        #1 check("rst_no_done", mon_done, 0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            i_start  = ($urandom % 6) == 0;
            i_inc    = WIDTH'($urandom);
            i_nsteps = CNT_W'($urandom % 20);
            i_hold   = ($urandom % 4) == 0;
            i_abort  = ($urandom % 40) == 0;
            i_rst_n  = ($urandom % 500) != 0;
        end
        @(posedge clk); #2;
        i_start = 0; i_hold = 0; i_abort = 0; i_rst_n = 1;
        repeat (40) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
